lfsr_prng: RTL and testbench

LFSR_PRNG -- requirements
Module: lfsr_prng

---
 rtl/lfsr_prng_pkg.sv | 17 +
 rtl/lfsr_prng_if.sv | 23 ++
 rtl/lfsr_prng_step.sv | 14 +
 rtl/lfsr_prng.sv | 96 +++++++++
 tb/tb_lfsr_prng.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_prng_pkg.sv
// Shared types for the LFSR PRNG: FSM state encoding, default tap mask and a saturating counter helper.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } lfsr_state_e;

  // Bits 63,62,60,59: maximal-length taps for a 64-bit XNOR LFSR.
  localparam logic [63:0] LFSR_DEFAULT_TAPS = 64'hD800_0000_0000_0000;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_prng_if.sv
// Seed-load and output-word channels of the LFSR PRNG.
// Both channels are valid/ready: a transfer happens on a rising clk edge where valid && ready are both high; valid must not depend on ready.
interface lfsr_prng_if #(
  parameter int WIDTH = 64,
  parameter int OUT_W = 8
);
  logic             seed_valid;
  logic [WIDTH-1:0] seed;
  logic             seed_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output seed_valid, seed, out_ready,
    input  seed_ready, out_valid, out_data
  );

  modport slave (
    input  seed_valid, seed, out_ready,
    output seed_ready, out_valid, out_data
  );
endinterface

// File: rtl/lfsr_prng_step.sv
// One combinational Fibonacci XNOR step of the LFSR; only TAPS[WIDTH-1:0] take part.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int          WIDTH = 64,
  parameter logic [63:0] TAPS  = LFSR_DEFAULT_TAPS
) (
  input  logic [WIDTH-1:0] s_in,
  output logic [WIDTH-1:0] s_out
);
  localparam logic [WIDTH-1:0] TAP_M = TAPS[WIDTH-1:0];

  assign s_out = {s_in[WIDTH-2:0], ~(^(s_in & TAP_M))};
endmodule

// File: rtl/lfsr_prng.sv
// LFSR PRNG: loads a seed, emits OUT_W-bit words and advances OUT_W steps per accepted word.
// Define LFSR_PRNG_LOCKUP_EN to trap the all-ones lock-up state in LOCK until a new seed arrives.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int          WIDTH = 64,
  parameter logic [63:0] TAPS  = LFSR_DEFAULT_TAPS,
  parameter int          OUT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  lfsr_prng_if.slave        bus,
  output logic [WIDTH-1:0]  state_o,
  output logic              lockup,
  output logic [31:0]       word_cnt,
  output lfsr_state_e       fsm_state
);

`ifdef LFSR_PRNG_LOCKUP_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  lfsr_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             rdy_q;
  logic             seed_fire;
  logic [WIDTH-1:0] chain [OUT_W+1];

  function automatic logic is_lock(input logic [WIDTH-1:0] v);
    return LOCK_EN && (&v);
  endfunction

  // OUT_W single steps chained so one accepted word advances the whole stride.
  assign chain[0] = s_q;
  for (genvar i = 0; i < OUT_W; i++) begin : g_step
    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
      .s_in  (chain[i]),
      .s_out (chain[i+1])
    );
  end

  assign seed_fire = bus.seed_valid && rdy_q;

  always_comb begin
    fsm_d = fsm_q;
    s_d   = s_q;
    cnt_d = cnt_q;
    if (seed_fire) begin
      // A seed wins over a same-cycle word handshake; the word is not consumed.
      s_d   = bus.seed;
      fsm_d = is_lock(bus.seed) ? LOCK : RUN;
    end else begin
      case (fsm_q)
        RUN: begin
          if (bus.out_ready) begin
            s_d   = chain[OUT_W];
            cnt_d = sat_inc32(cnt_q);
            if (is_lock(chain[OUT_W])) fsm_d = LOCK;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= IDLE;
      s_q   <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      s_q   <= s_d;
      cnt_q <= cnt_d;
      rdy_q <= 1'b1;
    end
  end

  assign bus.seed_ready = rdy_q;
  assign bus.out_valid  = (fsm_q == RUN);
  assign bus.out_data   = s_q[WIDTH-1 -: OUT_W];
  assign state_o        = s_q;
  assign word_cnt       = cnt_q;
  assign fsm_state      = fsm_q;

`ifdef LFSR_PRNG_LOCKUP_EN
  assign lockup = (fsm_q == LOCK);
`else
  assign lockup = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: a 16-bit OUT_W=1 instance and the default 64-bit OUT_W=8 instance.
module tb_lfsr_prng;
  import lfsr_pkg::*;

`ifdef LFSR_PRNG_LOCKUP_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam logic [63:0] TAPS16 = 64'h0000_0000_0000_D008;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  lfsr_prng_if #(.WIDTH(16), .OUT_W(1)) if16 ();
  lfsr_prng_if #(.WIDTH(64), .OUT_W(8)) if64 ();

  logic [15:0] state16;
  logic        lockup16;
  logic [31:0] cnt16;
  lfsr_state_e fsm16;
  logic [63:0] state64;
  logic        lockup64;
  logic [31:0] cnt64;
  lfsr_state_e fsm64;

  lfsr_prng #(.WIDTH(16), .TAPS(TAPS16), .OUT_W(1)) dut16 (
    .clk(clk), .reset(reset), .bus(if16),
    .state_o(state16), .lockup(lockup16), .word_cnt(cnt16), .fsm_state(fsm16)
  );

  lfsr_prng dut64 (
    .clk(clk), .reset(reset), .bus(if64),
    .state_o(state64), .lockup(lockup64), .word_cnt(cnt64), .fsm_state(fsm64)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m16;
  logic [31:0] mc16;
  bit          mrun16;
  logic [63:0] exp_q[$];

  // Reference step from the rule: shift left, new LSB = 1 when an even number of tapped bits are set.
  function automatic logic [63:0] ref_step(input logic [63:0] s, input int w, input logic [63:0] taps);
    logic [63:0] mask;
    int ones;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ones = $countones(s & taps & mask);
    return ((s << 1) | ((ones % 2 == 0) ? 64'd1 : 64'd0)) & mask;
  endfunction

  function automatic logic [15:0] ref16(input logic [15:0] s);
    return 16'(ref_step({48'd0, s}, 16, TAPS16));
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (state16 !== 16'h0 || fsm16 !== IDLE || if16.out_valid !== 1'b0 || lockup16 !== 1'b0 ||
        cnt16 !== 32'd0 || if16.seed_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset16: state=%h fsm=%0d ov=%b lk=%b cnt=%0d sr=%b, required 0/IDLE/0/0/0/0",
               state16, fsm16, if16.out_valid, lockup16, cnt16, if16.seed_ready);
    end
    n_cmp++;
    if (state64 !== 64'h0 || fsm64 !== IDLE || if64.out_valid !== 1'b0 || lockup64 !== 1'b0 ||
        cnt64 !== 32'd0 || if64.seed_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset64: state=%h fsm=%0d ov=%b lk=%b cnt=%0d sr=%b, required 0/IDLE/0/0/0/0",
               state64, fsm64, if64.out_valid, lockup64, cnt64, if64.seed_ready);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (if16.seed_ready !== 1'b1 || if64.seed_ready !== 1'b1 || if16.out_valid !== 1'b0 || fsm16 !== IDLE) begin
      n_bad++;
      $display("FAIL post_reset: sr16=%b sr64=%b ov16=%b fsm16=%0d, required 1/1/0/IDLE",
               if16.seed_ready, if64.seed_ready, if16.out_valid, fsm16);
    end
    // out_ready is ignored while no seed has been loaded
    if16.out_ready = 1'b1;
    if64.out_ready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (cnt16 !== 32'd0 || state16 !== 16'h0 || if16.out_valid !== 1'b0 || cnt64 !== 32'd0) begin
      n_bad++;
      $display("FAIL idle_ignore: cnt16=%0d state16=%h ov16=%b cnt64=%0d, required 0/0000/0/0",
               cnt16, state16, if16.out_valid, cnt64);
    end
    if16.out_ready = 1'b0;
    if64.out_ready = 1'b0;
  endtask

  task automatic test_seed_zero();
    if16.seed_valid = 1'b1;
    if16.seed       = 16'h0000;
    tick();
    if16.seed_valid = 1'b0;
    m16 = 16'h0000; mc16 = 32'd0; mrun16 = 1'b1;
    n_cmp++;
    if (if16.out_valid !== 1'b1 || if16.out_data !== 1'b0 || state16 !== 16'h0000) begin
      n_bad++;
      $display("FAIL seed_zero: ov=%b data=%b state=%h, required 1/0/0000", if16.out_valid, if16.out_data, state16);
    end
    if16.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      m16 = ref16(m16);
      mc16++;
      n_cmp++;
      if (state16 !== m16 || if16.out_data !== m16[15] || cnt16 !== mc16) begin
        n_bad++;
        $display("FAIL step16[%0d]: state=%h data=%b cnt=%0d, required %h/%b/%0d",
                 i, state16, if16.out_data, cnt16, m16, m16[15], mc16);
      end
    end
    if16.out_ready = 1'b0;
    n_cmp++;
    if (state16 !== 16'h0007 || cnt16 !== 32'd3) begin
      n_bad++;
      $display("FAIL three_words: state=%h cnt=%0d, required 0007/3", state16, cnt16);
    end
  endtask

  task automatic test_backpressure();
    if16.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (state16 !== m16 || if16.out_data !== m16[15] || cnt16 !== mc16 || if16.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL backpressure[%0d]: state=%h data=%b cnt=%0d ov=%b, required %h/%b/%0d/1",
                 i, state16, if16.out_data, cnt16, if16.out_valid, m16, m16[15], mc16);
      end
    end
  endtask

  task automatic test_collision();
    if16.out_ready  = 1'b1;
    if16.seed_valid = 1'b1;
    if16.seed       = 16'h1234;
    tick();
    if16.seed_valid = 1'b0;
    if16.out_ready  = 1'b0;
    m16 = 16'h1234;
    n_cmp++;
    if (state16 !== 16'h1234 || cnt16 !== mc16 || if16.out_valid !== 1'b1 || if16.out_data !== 1'b0) begin
      n_bad++;
      $display("FAIL collision: state=%h cnt=%0d ov=%b data=%b, required 1234/%0d/1/0",
               state16, cnt16, if16.out_valid, if16.out_data, mc16);
    end
  endtask

  task automatic test_all_ones();
    if16.seed_valid = 1'b1;
    if16.seed       = 16'hFFFF;
    tick();
    if16.seed_valid = 1'b0;
    m16 = 16'hFFFF;
`ifdef LFSR_PRNG_LOCKUP_EN
    n_cmp++;
    if (lockup16 !== 1'b1 || if16.out_valid !== 1'b0 || fsm16 !== LOCK) begin
      n_bad++;
      $display("FAIL lock_enter: lk=%b ov=%b fsm=%0d, required 1/0/LOCK", lockup16, if16.out_valid, fsm16);
    end
    if16.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (state16 !== 16'hFFFF || cnt16 !== mc16 || lockup16 !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_hold: state=%h cnt=%0d lk=%b, required FFFF/%0d/1", state16, cnt16, lockup16, mc16);
    end
    if16.out_ready  = 1'b0;
    if16.seed_valid = 1'b1;
    if16.seed       = 16'h0001;
    tick();
    if16.seed_valid = 1'b0;
    m16 = 16'h0001;
    n_cmp++;
    if (lockup16 !== 1'b0 || if16.out_valid !== 1'b1 || state16 !== 16'h0001) begin
      n_bad++;
      $display("FAIL lock_exit: lk=%b ov=%b state=%h, required 0/1/0001", lockup16, if16.out_valid, state16);
    end
`else
    n_cmp++;
    if (lockup16 !== 1'b0 || if16.out_valid !== 1'b1 || fsm16 !== RUN) begin
      n_bad++;
      $display("FAIL ones_run: lk=%b ov=%b fsm=%0d, required 0/1/RUN", lockup16, if16.out_valid, fsm16);
    end
    if16.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      mc16++;
      n_cmp++;
      if (state16 !== 16'hFFFF || if16.out_data !== 1'b1 || cnt16 !== mc16 || lockup16 !== 1'b0) begin
        n_bad++;
        $display("FAIL ones_stream[%0d]: state=%h data=%b cnt=%0d lk=%b, required FFFF/1/%0d/0",
                 i, state16, if16.out_data, cnt16, lockup16, mc16);
      end
    end
    if16.out_ready = 1'b0;
`endif
    mrun16 = 1'b1;
  endtask

  task automatic test_random16();
    logic        sv;
    logic [15:0] sd;
    logic        rdy;
    for (int i = 0; i < 300; i++) begin
      sv  = ($urandom_range(0, 15) == 0);
      sd  = 16'($urandom);
      rdy = 1'($urandom_range(0, 1));
      if16.seed_valid = sv;
      if16.seed       = sd;
      if16.out_ready  = rdy;
      if (sv) begin
        m16    = sd;
        mrun16 = !(LOCK_EN && sd == 16'hFFFF);
      end else if (mrun16 && rdy) begin
        m16  = ref16(m16);
        mc16 = mc16 + 32'd1;
        if (LOCK_EN && m16 == 16'hFFFF) mrun16 = 1'b0;
      end
      tick();
      n_cmp++;
      if (state16 !== m16 || cnt16 !== mc16 || if16.out_valid !== mrun16 || if16.out_data !== m16[15]) begin
        n_bad++;
        $display("FAIL random16[%0d]: state=%h cnt=%0d ov=%b data=%b, required %h/%0d/%b/%b",
                 i, state16, cnt16, if16.out_valid, if16.out_data, m16, mc16, mrun16, m16[15]);
      end
    end
    if16.seed_valid = 1'b0;
    if16.out_ready  = 1'b0;
  endtask

  task automatic test_stream64();
    logic [63:0] m64;
    logic [63:0] e;
    logic        rdy;
    int          words;
    m64 = 64'h0123_4567_89AB_CDEF;
    e   = m64;
    for (int w = 0; w < 1000; w++) begin
      for (int k = 0; k < 8; k++) e = ref_step(e, 64, LFSR_DEFAULT_TAPS);
      exp_q.push_back(e);
    end
    if64.seed_valid = 1'b1;
    if64.seed       = m64;
    tick();
    if64.seed_valid = 1'b0;
    n_cmp++;
    if (state64 !== m64 || if64.out_valid !== 1'b1 || if64.out_data !== 8'h01) begin
      n_bad++;
      $display("FAIL seed64: state=%h ov=%b data=%h, required %h/1/01", state64, if64.out_valid, if64.out_data, m64);
    end
    words = 0;
    for (int c = 0; c < 4000 && words < 1000; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if64.out_ready = rdy;
      tick();
      if (rdy) begin
        m64 = exp_q.pop_front();
        words++;
      end
      n_cmp++;
      if (state64 !== m64 || if64.out_data !== m64[63:56] || cnt64 !== 32'(words)) begin
        n_bad++;
        $display("FAIL stream64[%0d]: state=%h data=%h cnt=%0d, required %h/%h/%0d",
                 c, state64, if64.out_data, cnt64, m64, m64[63:56], words);
      end
    end
    if64.out_ready = 1'b0;
    n_cmp++;
    if (words != 1000) begin
      n_bad++;
      $display("FAIL stream64_budget: words=%0d, required 1000", words);
    end
  endtask

  task automatic test_reset_midstream();
    if16.out_ready = 1'b1;
    if64.out_ready = 1'b1;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (if16.out_valid !== 1'b0 || if64.out_valid !== 1'b0 || cnt16 !== 32'd0 || state16 !== 16'h0 || cnt64 !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset: ov16=%b ov64=%b cnt16=%0d state16=%h cnt64=%0d, required 0/0/0/0000/0",
               if16.out_valid, if64.out_valid, cnt16, state16, cnt64);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (fsm16 !== IDLE || if16.out_valid !== 1'b0 || cnt16 !== 32'd0 || state16 !== 16'h0 || fsm64 !== IDLE) begin
      n_bad++;
      $display("FAIL idle_after_reset: fsm16=%0d ov16=%b cnt16=%0d state16=%h fsm64=%0d, required IDLE/0/0/0000/IDLE",
               fsm16, if16.out_valid, cnt16, state16, fsm64);
    end
    if16.out_ready  = 1'b0;
    if64.out_ready  = 1'b0;
    if16.seed_valid = 1'b1;
    if16.seed       = 16'h00AB;
    tick();
    if16.seed_valid = 1'b0;
    n_cmp++;
    if (fsm16 !== RUN || if16.out_valid !== 1'b1 || state16 !== 16'h00AB || cnt16 !== 32'd0) begin
      n_bad++;
      $display("FAIL reseed_after_reset: fsm=%0d ov=%b state=%h cnt=%0d, required RUN/1/00AB/0",
               fsm16, if16.out_valid, state16, cnt16);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    if16.seed_valid = 1'b0; if16.seed = '0; if16.out_ready = 1'b0;
    if64.seed_valid = 1'b0; if64.seed = '0; if64.out_ready = 1'b0;
    test_reset();
    test_seed_zero();
    test_backpressure();
    test_collision();
    test_all_ones();
    test_random16();
    test_stream64();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
